// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: instruction fetch and PC sequencing for the MIPS core.
// Fetches one word at a time over a req/rdy handshake. It holds that word,
// with its OPCode and Funct fields, until the core retires it. It then picks
// the next PC from the Jump and PCSrc inputs.
// Optional feature: define IMEM_TIMEOUT_EN to bound the FETCH wait to
// TIMEOUT_CYCLES cycles. On expiry the block parks in a sticky ERROR state.
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC       = 32'h0000_0000,
  parameter int          TIMEOUT_CYCLES = 16
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_rdy,
  input  logic [31:0] imem_rdata,
  input  logic        core_ready,
  input  logic        PCSrc,
  input  logic        Jump,
  output logic [31:0] instr,
  output logic        instr_valid,
  output logic [5:0]  OPCode,
  output logic [5:0]  Funct,
  output logic [31:0] pc,
  output logic [31:0] pc_plus4,
  output logic        fetch_err
);

`ifdef IMEM_TIMEOUT_EN
  typedef enum logic [1:0] {IDLE, FETCH, HOLD, ERROR} state_t;
`else
  typedef enum logic [1:0] {IDLE, FETCH, HOLD} state_t;
`endif

  // The low PC bits are forced to zero so that pc stays word aligned.
  localparam logic [31:0] RESET_PC_ALIGNED = {RESET_PC[31:2], 2'b00};

  state_t      state, state_next;
  logic [31:0] next_pc;
  logic [31:0] branch_off;
  logic        capture;
  logic        advance;
  logic        timeout_hit;

  assign capture = (state == FETCH) && imem_rdy;
  assign advance = (state == HOLD) && core_ready;

`ifdef IMEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] wait_cnt;

  // This is the last FETCH cycle without rdy. If rdy arrives in this same
  // cycle, the capture wins.
  assign timeout_hit = (state == FETCH) && !imem_rdy && (wait_cnt == CW'(TIMEOUT_CYCLES - 1));

  // Wait counter: held at zero outside FETCH, so it starts from zero on every
  // entry, and counts FETCH cycles that see no rdy.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)                wait_cnt <= '0;
    else if (state != FETCH)  wait_cnt <= '0;
    else if (!imem_rdy)       wait_cnt <= wait_cnt + 1'b1;
  end

  // Sticky timeout flag; only reset clears it.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)            fetch_err <= 1'b0;
    else if (timeout_hit) fetch_err <= 1'b1;
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign timeout_hit = 1'b0;
  assign fetch_err   = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    // NOTE: sequential state uses non-blocking assignments so that every
    // register samples pre-edge values, whatever order the blocks run in.
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  // Next-state logic. Reset aborts any request in flight by forcing IDLE.
  always_comb begin
    // NOTE: the default comes first so that every path assigns state_next;
    // without it, a missed branch would infer a latch.
    state_next = state;
    case (state)
      IDLE:  state_next = FETCH;
      FETCH: begin
        if (imem_rdy)         state_next = HOLD;
        else if (timeout_hit) state_next = state_t'(2'd3);
      end
      HOLD:  if (core_ready) state_next = FETCH;
      default: state_next = state;
    endcase
  end

  // PC candidates. The arithmetic wraps modulo 2^32. Jump takes priority
  // over a branch.
  assign pc_plus4   = pc + 32'd4;
  assign branch_off = {{14{instr[15]}}, instr[15:0], 2'b00};

  // Next-PC selection from the held instruction and the decoder outputs.
  always_comb begin
    next_pc = pc_plus4;
    if (Jump)       next_pc = {pc_plus4[31:28], instr[25:0], 2'b00};
    else if (PCSrc) next_pc = pc_plus4 + branch_off;
  end

  // Instruction capture in FETCH and PC update when HOLD retires.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc    <= RESET_PC_ALIGNED;
      instr <= '0;
    end else begin
      if (capture) instr <= imem_rdata;
      if (advance) pc    <= next_pc;
    end
  end

  assign imem_req    = (state == FETCH);
  assign imem_addr   = pc;
  assign instr_valid = (state == HOLD);
  assign OPCode      = instr[31:26];
  assign Funct       = instr[5:0];

endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit. A reference PC model computes
// each next address from the branch and jump rules.
// The timeout scenario runs only when IMEM_TIMEOUT_EN is defined.
module tb_instr_fetch_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_rdy = 1'b0;
  logic [31:0] imem_rdata = '0;
  logic        core_ready = 1'b0;
  logic        PCSrc = 1'b0;
  logic        Jump = 1'b0;
  logic [31:0] instr;
  logic        instr_valid;
  logic [5:0]  OPCode;
  logic [5:0]  Funct;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        fetch_err;

  int          checks = 0;
  int          failures = 0;
  logic [31:0] model_pc = 32'h0;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000), .TIMEOUT_CYCLES(4)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rdy(imem_rdy), .imem_rdata(imem_rdata),
    .core_ready(core_ready), .PCSrc(PCSrc), .Jump(Jump),
    .instr(instr), .instr_valid(instr_valid),
    .OPCode(OPCode), .Funct(Funct),
    .pc(pc), .pc_plus4(pc_plus4), .fetch_err(fetch_err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference next-PC computed from the instruction-set rules.
  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic [31:0] w,
                                           input logic br, input logic jp);
    logic [31:0] seq;
    int          off;
    seq = p + 32'd4;
    if (jp) return (seq & 32'hF000_0000) | ({6'b0, w[25:0]} << 2);
    if (br) begin
      off = $signed(w[15:0]);
      return seq + 32'(off * 4);
    end
    return seq;
  endfunction

  task automatic check_reset_values(input string tag);
    chk({tag, "_req"},   imem_req, 1'b0);
    chk({tag, "_addr"},  imem_addr, 32'h0);
    chk({tag, "_pc"},    pc, 32'h0);
    chk({tag, "_instr"}, instr, 32'h0);
    chk({tag, "_valid"}, instr_valid, 1'b0);
    chk({tag, "_err"},   fetch_err, 1'b0);
  endtask

  // Entered at a sample point in FETCH. Runs one full fetch/hold/retire cycle.
  task automatic fetch_one(input logic [31:0] word, input int rdy_dly, input int hold_dly,
                           input logic br, input logic jp);
    chk("fetch_req", imem_req, 1'b1);
    chk("fetch_addr", imem_addr, model_pc);
    for (int i = 0; i < rdy_dly; i++) begin
      imem_rdy = 1'b0;
      imem_rdata = $urandom;
      tick();
      chk("wait_req", imem_req, 1'b1);
      chk("wait_addr", imem_addr, model_pc);
      chk("wait_valid", instr_valid, 1'b0);
    end
    imem_rdy = 1'b1;
    imem_rdata = word;
    tick();
    imem_rdy = 1'b0;
    chk("hold_valid", instr_valid, 1'b1);
    chk("hold_req", imem_req, 1'b0);
    chk("hold_instr", instr, word);
    chk("hold_opcode", OPCode, word[31:26]);
    chk("hold_funct", Funct, word[5:0]);
    chk("hold_pc", pc, model_pc);
    chk("hold_pc_plus4", pc_plus4, model_pc + 32'd4);
    for (int i = 0; i < hold_dly; i++) begin
      core_ready = 1'b0;
      imem_rdy = 1'b1;
      imem_rdata = $urandom;
      PCSrc = 1'($urandom);
      Jump = 1'($urandom);
      tick();
      chk("stall_valid", instr_valid, 1'b1);
      chk("stall_instr", instr, word);
      chk("stall_pc", pc, model_pc);
    end
    imem_rdy = 1'b0;
    core_ready = 1'b1;
    PCSrc = br;
    Jump = jp;
    tick();
    core_ready = 1'b0;
    PCSrc = 1'($urandom);
    Jump = 1'($urandom);
    model_pc = ref_next(model_pc, word, br, jp);
  endtask

  initial begin
    // Reset state.
    tick();
    tick();
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // First fetch of an add instruction from zero-wait memory.
    fetch_one(32'h0000_0020, 0, 0, 1'b0, 1'b0);
    chk("first_next_addr", imem_addr, 32'h0000_0004);

    // rdy delayed 5 cycles; core_ready low 3 cycles.
    fetch_one(32'h0123_4820, 5, 3, 1'b0, 1'b0);
    fetch_one($urandom, 0, 0, 1'b0, 1'b0);
    fetch_one($urandom, 1, 0, 1'b0, 1'b0);

    // Branch back from pc 0x10 with offset -2.
    fetch_one(32'h1000_FFFE, 0, 0, 1'b1, 1'b0);
    chk("branch_addr", imem_addr, 32'h0000_000C);

    // Branch backwards past zero to the top of the address space.
    fetch_one(32'h1000_FFFA, 0, 1, 1'b1, 1'b0);
    chk("branch_neg_addr", imem_addr, 32'hFFFF_FFF8);
    fetch_one($urandom, 0, 0, 1'b0, 1'b0);
    fetch_one($urandom, 2, 0, 1'b0, 1'b0);
    chk("wrap_addr", imem_addr, 32'h0000_0000);

    // Jump has priority over a simultaneous branch.
    fetch_one(32'h0800_0100, 0, 0, 1'b1, 1'b1);
    chk("jump_prio_addr", imem_addr, 32'h0000_0400);

    // Random instruction stream with random latencies and decisions.
    for (int n = 0; n < 40; n++)
      fetch_one($urandom, int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
                1'($urandom), 1'($urandom));

    // Reset during a FETCH wait; a late rdy must be ignored.
    imem_rdy = 1'b0;
    tick();
    tick();
    #2 reset = 1'b1;
    #1 check_reset_values("rst_fetch");
    imem_rdy = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    tick();
    reset = 1'b0;
    tick();
    imem_rdy = 1'b0;
    chk("late_rdy_instr", instr, 32'h0);
    chk("late_rdy_valid", instr_valid, 1'b0);
    model_pc = 32'h0;
    fetch_one($urandom, 1, 0, 1'b0, 1'b0);
    fetch_one($urandom, 0, 0, 1'b0, 1'b0);

    // Reset during HOLD.
    imem_rdy = 1'b1;
    imem_rdata = 32'hCAFE_0020;
    tick();
    imem_rdy = 1'b0;
    chk("pre_rst_hold_valid", instr_valid, 1'b1);
    #2 reset = 1'b1;
    #1 check_reset_values("rst_hold");
    tick();
    reset = 1'b0;
    tick();
    model_pc = 32'h0;
    fetch_one(32'h0000_0020, 0, 0, 1'b0, 1'b0);
    chk("restart_next_addr", imem_addr, 32'h0000_0004);

`ifdef IMEM_TIMEOUT_EN
    // With no rdy at all, the timeout fires after 4 wait cycles.
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    imem_rdy = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("to_wait_err", fetch_err, 1'b0);
      chk("to_wait_req", imem_req, 1'b1);
    end
    tick();
    chk("to_err", fetch_err, 1'b1);
    chk("to_req", imem_req, 1'b0);
    chk("to_valid", instr_valid, 1'b0);
    imem_rdy = 1'b1;
    for (int i = 0; i < 2; i++) begin
      tick();
      chk("to_sticky_err", fetch_err, 1'b1);
      chk("to_sticky_req", imem_req, 1'b0);
      chk("to_sticky_pc", pc, 32'h0);
    end
    imem_rdy = 1'b0;
    reset = 1'b1;
    #1 chk("to_reset_err", fetch_err, 1'b0);
    tick();
    reset = 1'b0;
    tick();
    // rdy on the 4th wait cycle wins over the timeout.
    for (int i = 0; i < 3; i++) tick();
    imem_rdy = 1'b1;
    imem_rdata = 32'h0000_0022;
    tick();
    imem_rdy = 1'b0;
    chk("to_edge_err", fetch_err, 1'b0);
    chk("to_edge_valid", instr_valid, 1'b1);
    chk("to_edge_instr", instr, 32'h0000_0022);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instr_fetch_unit.md
Name: instr_fetch_unit

Overview:
- Sequential instruction-fetch and PC-sequencing block for the MIPS core.
- Sits upstream of the control decoder and drives the instruction word, so the decoder receives OPCode and Funct from this block.
- Consumes the decoder's PCSrc and Jump outputs to select the next PC.
- Talks to instruction memory over a req/rdy handshake with variable latency, and holds each instruction until the core retires it.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset. Must be word aligned.
- TIMEOUT_CYCLES, 16, maximum FETCH wait cycles before an error. Used only when IMEM_TIMEOUT_EN is defined.

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- imem_req  output  1  fetch request to instruction memory.
- imem_addr  output  32  fetch address; equals pc.
- imem_rdy  input  1  imem_rdata valid this cycle; sampled only in FETCH.
- imem_rdata  input  32  instruction word from memory.
- core_ready  input  1  core has finished the held instruction; sampled only in HOLD.
- PCSrc  input  1  take branch; from the control decoder.
- Jump  input  1  take jump; from the control decoder.
- instr  output  32  held instruction register.
- instr_valid  output  1  instr is valid and being presented.
- OPCode  output  6  instr[31:26].
- Funct  output  6  instr[5:0].
- pc  output  32  address of the held or currently fetched instruction.
- pc_plus4  output  32  pc + 4, modulo 2^32.
- fetch_err  output  1  sticky timeout flag; tied to 0 when IMEM_TIMEOUT_EN is undefined.

Behaviour:
- Reset is asynchronous, active-high; assertion takes effect immediately.
- While reset is high:
  - state = IDLE, pc = RESET_PC, instr = 0, instr_valid = 0, fetch_err = 0.
  - imem_req = 0, imem_addr = RESET_PC.
- Reset asserted mid-fetch or mid-hold aborts the operation with no PC update. Any later imem_rdy for the aborted request is ignored (the block is not in FETCH).
- imem_req = (state == FETCH). imem_addr = pc. Both are combinational from registers.
- instr_valid = (state == HOLD), registered via state.
- States:
  - IDLE -> FETCH unconditionally on the next clock. First request appears the first cycle after reset deasserts.
  - FETCH: imem_req = 1.
    - If imem_rdy = 1: instr <= imem_rdata; next state HOLD.
    - Otherwise remain in FETCH; pc stable.
    - Zero-wait memory (rdy in the first FETCH cycle) gives a minimum throughput of 2 cycles per instruction.
  - HOLD: instr, pc, OPCode and Funct are stable.
    - If core_ready = 1: pc <= next_pc; next state FETCH.
    - Otherwise remain in HOLD indefinitely; imem_rdy is ignored.
  - ERROR (only with IMEM_TIMEOUT_EN): terminal until reset.
- next_pc is evaluated in HOLD from the current inputs:
  - Jump = 1: {pc_plus4[31:28], instr[25:0], 2'b00}.
  - else PCSrc = 1: pc_plus4 + {{14{instr[15]}}, instr[15:0], 2'b00}.
  - else: pc_plus4.
- Jump has priority when Jump and PCSrc are both 1.
- All PC arithmetic is 32-bit and wraps modulo 2^32: pc = 32'hFFFF_FFFC sequential gives next_pc = 0.
- pc[1:0] is always 2'b00.
- PCSrc and Jump are ignored outside HOLD.

Optional Feature:
- Macro: IMEM_TIMEOUT_EN.
- Defined:
  - A wait counter clears on entry to FETCH and increments each FETCH cycle with imem_rdy = 0.
  - When the counter reaches TIMEOUT_CYCLES without rdy, the next state is ERROR and fetch_err <= 1 (sticky).
  - In ERROR: imem_req = 0, instr_valid = 0, pc frozen. Only reset exits ERROR.
  - imem_rdy arriving in the same cycle the counter reaches its limit wins: the data is captured and there is no error.
- Undefined:
  - No counter; FETCH waits forever.
  - fetch_err is constant 0; ERROR state is absent.

Test Plan:
- Reset release with RESET_PC = 0, zero-wait memory returning 32'h0000_0020 (add), core_ready = 1 -> imem_req high the first cycle after reset with imem_addr = 0; instr_valid high the next cycle with OPCode = 0, Funct = 6'h20; next fetch at addr 4.
- Branch: pc = 32'h0000_0010, instr = 32'h1000_FFFE, PCSrc = 1, Jump = 0 in HOLD -> next imem_addr = 32'h0000_000C.
- Jump priority: pc = 32'h4000_0000, instr = 32'h0800_0100, Jump = 1, PCSrc = 1 -> next imem_addr = 32'h4000_0400.
- Stall and wrap:
  - imem_rdy delayed 5 cycles -> imem_req held 6 cycles with stable addr.
  - core_ready low 3 cycles -> instr and pc stable, instr_valid held.
  - pc = 32'hFFFF_FFFC sequential -> next addr 0.
- Mid-operation reset: assert reset during FETCH wait and during HOLD -> outputs at reset values immediately; late imem_rdy ignored; fetch restarts at RESET_PC.
- IMEM_TIMEOUT_EN defined, TIMEOUT_CYCLES = 4:
  - No rdy -> fetch_err = 1 after 4 wait cycles, imem_req = 0, fetch_err stays high until reset.
  - rdy on the 4th cycle -> capture, fetch_err = 0.
